// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-master round-robin arbiter onto a shared DM/IO bus
// One access in flight; timeout abort returns zero data and an error pulse.
module mem_bus_arbiter #(
    parameter int TIMEOUT_CYC = 15
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [29:0] m0_addr,
    input  logic [3:0]  m0_be,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    output logic        m0_ack,
    output logic        m0_err,
    output logic        m0_stall,

    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [29:0] m1_addr,
    input  logic [3:0]  m1_be,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        m1_ack,
    output logic        m1_err,

    output logic        s_en,
    output logic        s_we,
    output logic [29:0] s_addr,
    output logic [3:0]  s_be,
    output logic [31:0] s_wdata,
    input  logic [31:0] s_rdata,
    input  logic        s_ready
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [3:0] TIMEOUT_LIM = 4'(TIMEOUT_CYC);

    logic [1:0]  state;
    logic        gnt;        // 0 = m0, 1 = m1
    logic        last_gnt;
    logic [3:0]  cnt;

    logic        any_req;
    logic        win;
    logic [3:0]  cnt_inc;
    logic        busy;
    logic        done;
    logic        tmo;
    logic        finish;
    logic [31:0] cap_data;

    always_comb begin
        any_req  = m0_req | m1_req;
        // On conflict the master not granted last wins; otherwise the lone requester.
        win      = (m0_req & m1_req) ? ~last_gnt : m1_req;
        cnt_inc  = cnt + 4'd1;
        busy     = (state == ST_BUSY);
        done     = busy & s_ready;
        tmo      = busy & ~s_ready & (cnt_inc == TIMEOUT_LIM);
        finish   = done | tmo;
        cap_data = (done & ~s_we) ? s_rdata : 32'd0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            gnt      <= 1'b0;
            last_gnt <= 1'b1;
            cnt      <= 4'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        gnt   <= win;
                        cnt   <= 4'd0;
                        state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (s_ready) begin
                        last_gnt <= gnt;
                        state    <= ST_RESP;
                    end else begin
                        // Counter saturates at the limit because BUSY is left on reaching it.
                        cnt <= cnt_inc;
                        if (tmo) begin
                            state <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s_en    <= 1'b0;
            s_we    <= 1'b0;
            s_addr  <= 30'd0;
            s_be    <= 4'd0;
            s_wdata <= 32'd0;
        end else if ((state == ST_IDLE) && any_req) begin
            s_en    <= 1'b1;
            s_we    <= win ? m1_we    : m0_we;
            s_addr  <= win ? m1_addr  : m0_addr;
            s_be    <= win ? m1_be    : m0_be;
            s_wdata <= win ? m1_wdata : m0_wdata;
        end else if (finish) begin
            // Address/data are left as-is; only enable and write strobe drop.
            s_en <= 1'b0;
            s_we <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m0_ack   <= 1'b0;
            m0_err   <= 1'b0;
            m0_rdata <= 32'd0;
            m1_ack   <= 1'b0;
            m1_err   <= 1'b0;
            m1_rdata <= 32'd0;
        end else begin
            m0_ack <= finish & ~gnt;
            m0_err <= tmo & ~gnt;
            m1_ack <= finish & gnt;
            m1_err <= tmo & gnt;
            if (finish & ~gnt) begin
                m0_rdata <= cap_data;
            end
            if (finish & gnt) begin
                m1_rdata <= cap_data;
            end
        end
    end

    assign m0_stall = m0_req & ~m0_ack;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - scoreboard bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_we;
    logic [29:0] m0_addr;
    logic [3:0]  m0_be;
    logic [31:0] m0_wdata, m0_rdata;
    logic        m0_ack, m0_err, m0_stall;
    logic        m1_req, m1_we;
    logic [29:0] m1_addr;
    logic [3:0]  m1_be;
    logic [31:0] m1_wdata, m1_rdata;
    logic        m1_ack, m1_err;
    logic        s_en, s_we;
    logic [29:0] s_addr;
    logic [3:0]  s_be;
    logic [31:0] s_wdata, s_rdata;
    logic        s_ready;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.TIMEOUT_CYC(15)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_be(m0_be), .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_err(m0_err), .m0_stall(m0_stall),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_be(m1_be), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_err(m1_err),
        .s_en(s_en), .s_we(s_we), .s_addr(s_addr), .s_be(s_be), .s_wdata(s_wdata),
        .s_rdata(s_rdata), .s_ready(s_ready)
    );

    typedef struct {
        logic        mst;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          ready_after = 1;
    logic [31:0] rd_key = 32'd0;
    int          busy_cnt = 0;
    int          busy_len = 0;
    int          en_rises = 0;
    logic        prev_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rdv(input logic [29:0] a);
        return {2'b00, a} ^ rd_key;
    endfunction

    task automatic push(input logic m, input logic [31:0] rd, input logic er);
        exp_t e;
        e.mst = m; e.rdata = rd; e.err = er;
        sb.push_back(e);
    endtask

    task automatic pop_cmp(input logic m, input logic [31:0] rd, input logic er);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ack master=%0d actual=ack required=none", m);
        end else begin
            e = sb.pop_front();
            chk("ack_master", 32'(m), 32'(e.mst));
            chk("ack_rdata", rd, e.rdata);
            chk("ack_err", 32'(er), 32'(e.err));
        end
    endtask

    task automatic wait_ack(input logic m, input int budget, output int cyc);
        cyc = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if ((!m && m0_ack) || (m && m1_ack)) begin
                cyc = i;
                break;
            end
        end
        if (cyc < 0) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout master=%0d actual=none required=ack", m);
        end
    endtask

    // Monitor: every ack pulse is matched against the scoreboard in order.
    initial begin
        forever begin
            @(negedge clk);
            if (m0_ack) pop_cmp(1'b0, m0_rdata, m0_err);
            if (m1_ack) pop_cmp(1'b1, m1_rdata, m1_err);
        end
    end

    // Target model: asserts s_ready on BUSY cycle ready_after (0 = never).
    initial begin
        s_ready = 1'b0;
        s_rdata = 32'd0;
        forever begin
            @(negedge clk);
            if (s_en) begin
                if (!prev_en) en_rises++;
                busy_cnt++;
                s_ready = (ready_after != 0) && (busy_cnt == ready_after);
                s_rdata = s_ready ? ({2'b00, s_addr} ^ rd_key) : 32'hDEAD_BEEF;
            end else begin
                if (prev_en) busy_len = busy_cnt;
                busy_cnt = 0;
                s_ready  = 1'b0;
            end
            prev_en = s_en;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int cyc;
        int r0;
        reset = 1'b0;
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_be = 4'hF; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_be = 4'hF; m1_wdata = 0;
        repeat (3) @(negedge clk);
        chk("rst_s_en", 32'(s_en), 32'd0);
        chk("rst_s_we", 32'(s_we), 32'd0);
        chk("rst_s_addr", 32'(s_addr), 32'd0);
        chk("rst_acks", 32'({m0_ack, m1_ack, m0_err, m1_err}), 32'd0);
        chk("rst_m0_rdata", m0_rdata, 32'd0);
        chk("rst_m1_rdata", m1_rdata, 32'd0);
        reset = 1'b1;

        // Conflict from reset: m0, then m1, then m0 again.
        rd_key = 32'h5A5A_0000; ready_after = 1;
        m0_addr = 30'h100; m1_addr = 30'h200;
        m0_req = 1; m1_req = 1;
        push(1'b0, rdv(30'h100), 1'b0);
        push(1'b1, rdv(30'h200), 1'b0);
        push(1'b0, rdv(30'h100), 1'b0);
        wait_ack(1'b0, 8, cyc); chk("conf_lat0", cyc, 32'd2);
        wait_ack(1'b1, 8, cyc); chk("conf_lat1", cyc, 32'd3);
        m1_req = 0;
        wait_ack(1'b0, 8, cyc); chk("conf_lat2", cyc, 32'd3);
        m0_req = 0;
        @(negedge clk);
        chk("conf_ack_pulse", 32'(m0_ack), 32'd0);

        // Single m0 read.
        rd_key = 32'h1234_ABCD ^ {2'b00, 30'h0000C01};
        m0_addr = 30'h0000C01; m0_we = 0; m0_req = 1;
        push(1'b0, 32'h1234_ABCD, 1'b0);
        @(negedge clk);
        chk("rd_s_en", 32'(s_en), 32'd1);
        chk("rd_s_addr", 32'(s_addr), 32'h0000C01);
        chk("rd_stall_busy", 32'(m0_stall), 32'd1);
        @(negedge clk);
        chk("rd_ack", 32'(m0_ack), 32'd1);
        chk("rd_stall_ack", 32'(m0_stall), 32'd0);
        chk("rd_s_en_resp", 32'(s_en), 32'd0);
        m0_req = 0;
        @(negedge clk);
        chk("rd_ack_drop", 32'(m0_ack), 32'd0);
        chk("rd_hold", m0_rdata, 32'h1234_ABCD);

        // m1 write with no s_ready: timeout abort.
        ready_after = 0;
        m1_we = 1; m1_addr = 30'h2AAA_AAA; m1_be = 4'hC; m1_wdata = 32'hCAFE_F00D; m1_req = 1;
        push(1'b1, 32'd0, 1'b1);
        @(negedge clk);
        chk("to_s_we", 32'(s_we), 32'd1);
        chk("to_s_wdata", s_wdata, 32'hCAFE_F00D);
        chk("to_s_be", 32'(s_be), 32'hC);
        wait_ack(1'b1, 20, cyc); chk("to_lat", cyc, 32'd15);
        chk("to_err", 32'(m1_err), 32'd1);
        chk("to_s_we_after", 32'(s_we), 32'd0);
        chk("to_rdata", m1_rdata, 32'd0);
        m1_req = 0; m1_we = 0;
        @(negedge clk);
        chk("to_busy_len", busy_len, 32'd15);
        chk("to_err_pulse", 32'(m1_err), 32'd0);

        // s_ready on the 15th BUSY cycle wins over the timeout.
        ready_after = 15;
        rd_key = 32'h0F0F_0F0F;
        m1_addr = 30'h0ABC_DEF; m1_req = 1;
        push(1'b1, rdv(30'h0ABC_DEF), 1'b0);
        wait_ack(1'b1, 20, cyc); chk("edge_lat", cyc, 32'd16);
        chk("edge_err", 32'(m1_err), 32'd0);
        m1_req = 0;
        @(negedge clk);
        chk("edge_busy_len", busy_len, 32'd15);

        // Reset mid-BUSY with m0_req held.
        ready_after = 0;
        m0_addr = 30'h0000123; m0_req = 1;
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_s_en", 32'(s_en), 32'd0);
        chk("mid_rst_s_addr", 32'(s_addr), 32'd0);
        chk("mid_rst_ack", 32'({m0_ack, m0_err}), 32'd0);
        chk("mid_rst_rdata", m0_rdata, 32'd0);
        chk("mid_rst_stall", 32'(m0_stall), 32'd1);
        @(negedge clk);
        reset = 1'b1; ready_after = 1;
        push(1'b0, rdv(30'h0000123), 1'b0);
        wait_ack(1'b0, 8, cyc); chk("post_rst_lat", cyc, 32'd2);
        m0_req = 0;
        @(negedge clk);

        // m0 drops req one cycle into BUSY.
        ready_after = 3;
        r0 = en_rises;
        m0_addr = 30'h0000456; m0_req = 1;
        push(1'b0, rdv(30'h0000456), 1'b0);
        @(negedge clk);
        m0_req = 0;
        wait_ack(1'b0, 8, cyc); chk("drop_lat", cyc, 32'd3);
        repeat (4) @(negedge clk);
        chk("drop_single_en", en_rises - r0, 32'd1);

        chk("sb_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 15 (range 1..15): BUSY cycles without s_ready before the access is aborted.
REQ-002 clk  in  1  system clock; all state changes on rising edge.
REQ-003 reset  in  1  asynchronous, active-low; 0 forces reset state immediately.
REQ-004 m0_req  in  1  CPU Mem-stage access request; level, held until m0_ack.
REQ-005 m0_we / m0_addr / m0_be / m0_wdata  in  1/30/4/32  CPU write enable, word address [31:2], byte enables, write data.
REQ-006 m0_rdata / m0_ack / m0_err / m0_stall  out  32/1/1/1  read data, completion pulse, error pulse, pipeline-freeze request.
REQ-007 m1_req, m1_we, m1_addr, m1_be, m1_wdata, m1_rdata, m1_ack, m1_err  same widths  second requester (DMA/debug); no stall output.
REQ-008 s_en / s_we / s_addr / s_be / s_wdata  out  1/1/30/4/32  shared DM/IO bus command, registered.
REQ-009 s_rdata / s_ready  in  32/1  target read data; s_ready=1 completes the access in that cycle.

Function
REQ-010 FSM states SHALL be IDLE, BUSY, RESP; one access in flight at most.
REQ-011 IDLE: no request -> stay IDLE. A request -> latch the winner's we/addr/be/wdata into s_* regs, record gnt, clear timeout counter, go BUSY.
REQ-012 Arbitration: single requester wins. Both requesting -> round-robin; winner is the master not granted last. last_gnt resets to m1, so m0 wins the first conflict.
REQ-013 BUSY: s_en=1. s_* regs SHALL stay stable for the whole access.
REQ-014 BUSY with s_ready=1: capture s_rdata into gnt master's rdata (writes capture 0), go RESP, update last_gnt.
REQ-015 BUSY with s_ready=0: counter +1. When counter reaches TIMEOUT_CYC: abort, rdata=0, flag error, go RESP.
REQ-016 s_ready and the timeout in the same cycle: s_ready wins; no error.
REQ-017 RESP: s_en=0. Pulse gnt master's ack for exactly one cycle, plus err on abort. Go IDLE unconditionally; no arbitration in RESP, so a held request is not re-issued.
REQ-018 Latency: req sampled at edge n -> s_en high from n+1 -> ready at earliest cycle n+1 -> ack high cycle n+2. Best-case back-to-back throughput is one access per 3 cycles.
REQ-019 Requester drops req during BUSY: the latched access SHALL still complete and ack. A requester SHALL NOT change its command fields while req is high.
REQ-020 m0_stall = m0_req & ~m0_ack (combinational). It is high while m0 waits or is serviced and low in its ack cycle.
REQ-021 mX_rdata SHALL hold its value until the next completion for that master.
REQ-022 s_we SHALL be forced to 0 whenever s_en=0, so an aborted or idle bus never writes.
REQ-023 Counter width 4 bits; it SHALL NOT wrap inside BUSY.

Reset
REQ-024 reset=0 asynchronously forces: state=IDLE, last_gnt=m1, counter=0, s_en=0, s_we=0, s_addr=0, s_be=0, s_wdata=0, all acks/errs=0, m0_rdata=m1_rdata=0.
REQ-025 Reset during BUSY or RESP: the access is dropped with no ack and no err. After release, a still-asserted request is arbitrated fresh from IDLE.
REQ-026 Deassertion of reset is synchronous to clk; first arbitration happens on the first edge with reset=1.

Verification
REQ-027 Single m0 read: addr=0x000_0C01, target s_ready on the first BUSY cycle with s_rdata=0x1234_ABCD -> s_en 1 cycle; m0_ack pulse at n+2; m0_rdata=0x1234_ABCD; m0_stall low from the ack cycle.
REQ-028 Conflict: m0 and m1 request the same cycle from reset -> m0 served first. Both re-request after the acks -> m1 served next, then m0 (alternation).
REQ-029 Timeout: m1 write, s_ready held 0 -> exactly 15 BUSY cycles, then m1_ack=1 and m1_err=1 in one cycle, s_we=0 after abort, m1_rdata=0.
REQ-030 s_ready asserted on exactly the 15th BUSY cycle -> normal completion; m1_err=0.
REQ-031 reset pulsed low mid-BUSY with m0_req held -> all outputs 0 at once, no ack. After release, m0 re-arbitrated; ack arrives 2 cycles after the first sampling edge.
REQ-032 m0 drops req one cycle into BUSY -> access still completes, one m0_ack pulse, no second s_en.
